soc_addr_decode_stage: RTL and testbench
========================================

# soc_addr_decode_stage

Registered address-decode stage that sits directly in front of the SoC AXI crossbar. It accepts one request beat per cycle: address, ID and read/write flag. It resolves the address against the fixed SoC address map (13 peripheral rules, Debug=0 … HYAXI=12) and forwards the beat with a slave index and a decode-error flag. Unmapped accesses are tagged for the error slave, and an optional capture unit records the error count and the first faulting address.

## Interface
Parameters:
- AddrWidth, 64, request address width
- IdWidth, 5, transaction ID width (SoC master-side ID width)
- IdxWidth, 4, slave index width; index 13 means "no rule hit"
- ErrCntWidth, 16, width of the decode-error counter

Ports:
- clk_i  in  1  single clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  1  request beat valid
- req_ready_o  out  1  stage can accept a beat
- req_addr_i  in  AddrWidth  request address
- req_id_i  in  IdWidth  request ID
- req_write_i  in  1  1 = write, 0 = read
- out_valid_o  out  1  decoded beat valid
- out_ready_i  in  1  crossbar accepts the beat
- out_addr_o  out  AddrWidth  forwarded address
- out_id_o  out  IdWidth  forwarded ID
- out_write_o  out  1  forwarded R/W flag
- out_idx_o  out  IdxWidth  matched slave index (0..12), or 13 on a miss
- out_decerr_o  out  1  address matched no rule
- err_cnt_o  out  ErrCntWidth  saturating count of decode errors
- err_valid_o  out  1  err_addr_o holds a captured address
- err_addr_o  out  AddrWidth  address of the first decode error since the last clear
- err_clear_i  in  1  clears the counter and the capture

## Operation
- Decode rule: hit when base <= addr < base+length, using full 64-bit unsigned compares. The end address is exclusive.
- Rules, by index: 0 Debug 0x0/0x1000; 1 ROM 0x1_0000/0x1_0000; 2 CLINT 0x200_0000/0xC_0000; 3 PLIC 0xC00_0000/0x3FF_FFFF; 4 Cluster 0x1000_0000/0x40_0000; 5 L2SPM 0x1C00_0000/0x1_0000; 6 APB_SLVS 0x1A10_0000/0x12_3000; 7 Timer 0x1800_0000/0x1000; 8 SPI 0x2000_0000/0x80_0000; 9 Ethernet 0x3000_0000/0x1_0000; 10 UART 0x4000_0000/0x1000; 11 AXILite 0x1040_0000/0x10_0000; 12 HYAXI 0x8000_0000/0x2000_0000.
- Rules do not overlap. If more than one rule ever matched, the lowest index would win.
- A miss sets out_idx_o=13 and out_decerr_o=1. Any address >= 0x1_0000_0000 is a miss.
- Buffering: a two-entry skid, made of an output register plus a skid register, with states EMPTY, ONE and TWO.
  - EMPTY: an accepted beat goes to ONE.
  - ONE: accept without drain stays in ONE if the output drains, otherwise moves to TWO. Drain without accept goes to EMPTY.
  - TWO: req_ready_o=0. When the output drains, the skid entry moves into the output register and the state goes to ONE.
- req_ready_o is a registered signal, equal to (state != TWO).
- Ordering is strictly FIFO. Decode happens before the skid register, so both entries hold decoded data.
- The out_* payload is held stable while out_valid_o=1 and out_ready_i=0.
- Error events are counted at input acceptance (req_valid_i && req_ready_o && miss).
- err_cnt_o increments by 1 per event and saturates at all-ones.
- The first event after reset or clear loads err_addr_o and sets err_valid_o. Later events do not overwrite the captured address.
- err_clear_i has priority: the counter and capture are cleared. An event in the same cycle is then applied on top, giving err_cnt_o=1 with err_addr_o equal to that event's address.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on out_* after edge N.
- Throughput is 1 beat per cycle while out_ready_i=1.
- Reset values (synchronous, rst_ni low at an edge):
  - state=EMPTY, out_valid_o=0, req_ready_o=1.
  - out_addr_o=0, out_id_o=0, out_write_o=0, out_idx_o=0, out_decerr_o=0.
  - err_cnt_o=0, err_valid_o=0, err_addr_o=0.
- Reset mid-operation discards both buffered entries, and no error event is counted in the reset cycle.
- No combinational path exists from out_ready_i to req_ready_o.
- The decode compare is combinational on the input side, within one cycle.

## Configuration
- Macro: SOC_DECODE_ERR_CAPTURE_EN.
- When defined: the counter and first-address capture are built as described above.
- When undefined:
  - err_cnt_o, err_valid_o and err_addr_o are tied to 0, and err_clear_i is ignored.
  - No capture registers are built.
  - Decode, out_decerr_o and the handshake are unchanged.

## Test plan
- Boundaries, with out_ready_i=1:
  - 0x9FFF_FFFF -> idx 12, decerr 0.
  - 0xA000_0000 -> idx 13, decerr 1.
  - 0x103F_FFFF -> idx 4; 0x1040_0000 -> idx 11.
  - 0x1_8000_0000 -> decerr 1.
  - Each result appears exactly 1 cycle after acceptance.
- Backpressure: hold out_ready_i=0 and send 3 beats (IDs 1, 2, 3).
  - Beats 1 and 2 are accepted, and req_ready_o falls to 0 on the cycle after the second accept.
  - Raise out_ready_i: beats 1, 2, 3 exit in order with a stable payload.
- Throughput: 20 back-to-back beats with out_ready_i=1 -> 20 outputs in 20 consecutive cycles, req_ready_o never low.
- Error capture, macro defined: misses at 0xA000_0000, 0xB000_0000, 0xC000_0000 -> err_cnt_o=3, err_addr_o=0xA000_0000.
- Clear/event collision: assert err_clear_i in the same cycle as a miss accept at 0xD000_0000 -> err_cnt_o=1, err_valid_o=1, err_addr_o=0xD000_0000. Counter preset near max with ErrCntWidth=4 -> holds at 15.
- Reset mid-stream: in state TWO, pull rst_ni low for 1 edge -> out_valid_o=0, req_ready_o=1, err_cnt_o=0. The discarded beats never appear on out_*.

Source files
------------

// File: rtl/soc_addr_decode_stage.sv
// Registered SoC address-map decode stage with a two-entry skid buffer.
// Optional decode-error counter/first-address capture: define SOC_DECODE_ERR_CAPTURE_EN.
module soc_addr_decode_stage #(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned IdWidth     = 5,
    parameter int unsigned IdxWidth    = 4,
    parameter int unsigned ErrCntWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic [IdWidth-1:0]     req_id_i,
    input  logic                   req_write_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [AddrWidth-1:0]   out_addr_o,
    output logic [IdWidth-1:0]     out_id_o,
    output logic                   out_write_o,
    output logic [IdxWidth-1:0]    out_idx_o,
    output logic                   out_decerr_o,
    output logic [ErrCntWidth-1:0] err_cnt_o,
    output logic                   err_valid_o,
    output logic [AddrWidth-1:0]   err_addr_o,
    input  logic                   err_clear_i
);

    localparam int unsigned NumRules = 13;

    localparam logic [63:0] RuleBase [NumRules] = '{
        64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000,
        64'h1000_0000, 64'h1C00_0000, 64'h1A10_0000, 64'h1800_0000,
        64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h1040_0000,
        64'h8000_0000
    };

    localparam logic [63:0] RuleLen [NumRules] = '{
        64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF,
        64'h0040_0000, 64'h0001_0000, 64'h0012_3000, 64'h0000_1000,
        64'h0080_0000, 64'h0001_0000, 64'h0000_1000, 64'h0010_0000,
        64'h2000_0000
    };

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [IdWidth-1:0]   id;
        logic                 write;
        logic [IdxWidth-1:0]  idx;
        logic                 decerr;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_e;

    state_e      state_q;
    beat_t       out_q;
    beat_t       skid_q;
    beat_t       in_beat;
    logic        out_valid_q;
    logic        ready_q;
    logic [63:0] addr64;
    logic [IdxWidth-1:0] dec_idx;
    logic        dec_miss;
    logic        accept;
    logic        drain;

    assign accept = req_valid_i && ready_q;
    assign drain  = out_valid_q && out_ready_i;

    always_comb begin
        addr64 = '0;
        addr64[AddrWidth-1:0] = req_addr_i;
        dec_idx  = IdxWidth'(NumRules);
        dec_miss = 1'b1;
        // Scan from the top so the lowest matching index is the one kept.
        for (int unsigned i = NumRules; i > 0; i--) begin
            if ((addr64 >= RuleBase[i-1]) && (addr64 < (RuleBase[i-1] + RuleLen[i-1]))) begin
                dec_idx  = IdxWidth'(i - 1);
                dec_miss = 1'b0;
            end
        end
    end

    always_comb begin
        in_beat.addr   = req_addr_i;
        in_beat.id     = req_id_i;
        in_beat.write  = req_write_i;
        in_beat.idx    = dec_idx;
        in_beat.decerr = dec_miss;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_q       <= in_beat;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    case ({accept, drain})
                        2'b11: out_q <= in_beat;
                        2'b10: begin
                            skid_q  <= in_beat;
                            ready_q <= 1'b0;
                            state_q <= TWO;
                        end
                        2'b01: begin
                            out_valid_q <= 1'b0;
                            state_q     <= EMPTY;
                        end
                        default: ;
                    endcase
                end
                TWO: begin
                    if (drain) begin
                        out_q   <= skid_q;
                        ready_q <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_addr_o   = out_q.addr;
    assign out_id_o     = out_q.id;
    assign out_write_o  = out_q.write;
    assign out_idx_o    = out_q.idx;
    assign out_decerr_o = out_q.decerr;

`ifdef SOC_DECODE_ERR_CAPTURE_EN
    logic [ErrCntWidth-1:0] err_cnt_q;
    logic                   err_valid_q;
    logic [AddrWidth-1:0]   err_addr_q;
    logic                   err_event;

    assign err_event = accept && dec_miss;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_cnt_q   <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (err_clear_i) begin
            // Clear wins, but a same-cycle event still lands on the fresh state.
            err_cnt_q   <= err_event ? ErrCntWidth'(1) : '0;
            err_valid_q <= err_event;
            err_addr_q  <= err_event ? req_addr_i : '0;
        end else if (err_event) begin
            if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + ErrCntWidth'(1);
            end
            if (!err_valid_q) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= req_addr_i;
            end
        end
    end

    assign err_cnt_o   = err_cnt_q;
    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
`else
    logic unused_err_clear;
    assign unused_err_clear = err_clear_i;
    assign err_cnt_o   = '0;
    assign err_valid_o = 1'b0;
    assign err_addr_o  = '0;
`endif

endmodule

// File: tb/tb_soc_addr_decode_stage.sv
// Directed bench for soc_addr_decode_stage: decode table, skid backpressure, error capture, reset.
module tb_soc_addr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [4:0]  req_id;
    logic        req_write;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_addr;
    logic [4:0]  out_id;
    logic        out_write;
    logic [3:0]  out_idx;
    logic        out_decerr;
    logic [15:0] err_cnt;
    logic        err_valid;
    logic [63:0] err_addr;
    logic        err_clear;

    logic        s_req_ready;
    logic        s_out_valid;
    logic [63:0] s_out_addr;
    logic [4:0]  s_out_id;
    logic        s_out_write;
    logic [3:0]  s_out_idx;
    logic        s_out_decerr;
    logic [3:0]  s_err_cnt;
    logic        s_err_valid;
    logic [63:0] s_err_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    soc_addr_decode_stage #(
        .AddrWidth(64), .IdWidth(5), .IdxWidth(4), .ErrCntWidth(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_id_i(req_id), .req_write_i(req_write),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_id_o(out_id), .out_write_o(out_write),
        .out_idx_o(out_idx), .out_decerr_o(out_decerr),
        .err_cnt_o(err_cnt), .err_valid_o(err_valid), .err_addr_o(err_addr),
        .err_clear_i(err_clear)
    );

    soc_addr_decode_stage #(
        .AddrWidth(64), .IdWidth(5), .IdxWidth(4), .ErrCntWidth(4)
    ) dut_small (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(s_req_ready),
        .req_addr_i(req_addr), .req_id_i(req_id), .req_write_i(req_write),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready),
        .out_addr_o(s_out_addr), .out_id_o(s_out_id), .out_write_o(s_out_write),
        .out_idx_o(s_out_idx), .out_decerr_o(s_out_decerr),
        .err_cnt_o(s_err_cnt), .err_valid_o(s_err_valid), .err_addr_o(s_err_addr),
        .err_clear_i(err_clear)
    );

    typedef struct {
        logic [63:0] addr;
        logic [4:0]  id;
        logic        wr;
        logic [3:0]  idx;
        logic        decerr;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [4:0] id, input logic wr);
        req_valid = v;
        req_addr  = a;
        req_id    = id;
        req_write = wr;
    endtask

    task automatic add_vec(input logic [63:0] a, input logic [3:0] idx);
        vec_t v;
        v.addr   = a;
        v.id     = 5'(vecs.size() * 3 + 1);
        v.wr     = vecs.size() % 2 == 1;
        v.idx    = idx;
        v.decerr = (idx == 4'd13);
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nmiss;
        logic [63:0] first_miss;
        rst_ni    = 1'b0;
        out_ready = 1'b1;
        err_clear = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        tick();
        tick();

        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset out_addr", out_addr, 64'd0);
        chk("reset out_id", 64'(out_id), 64'd0);
        chk("reset out_write", 64'(out_write), 64'd0);
        chk("reset out_idx", 64'(out_idx), 64'd0);
        chk("reset out_decerr", 64'(out_decerr), 64'd0);
        chk("reset err_cnt", 64'(err_cnt), 64'd0);
        chk("reset err_valid", 64'(err_valid), 64'd0);
        chk("reset err_addr", err_addr, 64'd0);
        rst_ni = 1'b1;

        add_vec(64'h0, 4'd0);           add_vec(64'hFFF, 4'd0);
        add_vec(64'h1000, 4'd13);       add_vec(64'h1_0000, 4'd1);
        add_vec(64'h1_FFFF, 4'd1);      add_vec(64'h2_0000, 4'd13);
        add_vec(64'h200_0000, 4'd2);    add_vec(64'h20B_FFFF, 4'd2);
        add_vec(64'h20C_0000, 4'd13);   add_vec(64'hC00_0000, 4'd3);
        add_vec(64'hFFF_FFFE, 4'd3);    add_vec(64'hFFF_FFFF, 4'd13);
        add_vec(64'h1000_0000, 4'd4);   add_vec(64'h103F_FFFF, 4'd4);
        add_vec(64'h1040_0000, 4'd11);  add_vec(64'h104F_FFFF, 4'd11);
        add_vec(64'h1050_0000, 4'd13);  add_vec(64'h1800_0000, 4'd7);
        add_vec(64'h1800_1000, 4'd13);  add_vec(64'h1A10_0000, 4'd6);
        add_vec(64'h1A22_2FFF, 4'd6);   add_vec(64'h1A22_3000, 4'd13);
        add_vec(64'h1C00_0000, 4'd5);   add_vec(64'h1C00_FFFF, 4'd5);
        add_vec(64'h1C01_0000, 4'd13);  add_vec(64'h2000_0000, 4'd8);
        add_vec(64'h207F_FFFF, 4'd8);   add_vec(64'h2080_0000, 4'd13);
        add_vec(64'h3000_0000, 4'd9);   add_vec(64'h3000_FFFF, 4'd9);
        add_vec(64'h4000_0000, 4'd10);  add_vec(64'h4000_0FFF, 4'd10);
        add_vec(64'h4000_1000, 4'd13);  add_vec(64'h8000_0000, 4'd12);
        add_vec(64'h9FFF_FFFF, 4'd12);  add_vec(64'hA000_0000, 4'd13);
        add_vec(64'h1_0000_0000, 4'd13); add_vec(64'h1_8000_0000, 4'd13);
        add_vec(64'hFFFF_FFFF_FFFF_FFFF, 4'd13);

        // Back-to-back stream: each beat must appear exactly one edge after it is offered.
        nmiss = 0;
        first_miss = '0;
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].addr, vecs[i].id, vecs[i].wr);
            if (vecs[i].decerr) begin
                if (nmiss == 0) first_miss = vecs[i].addr;
                nmiss++;
            end
            tick();
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d req_ready", i), 64'(req_ready), 64'd1);
            chk($sformatf("vec%0d out_idx", i), 64'(out_idx), 64'(vecs[i].idx));
            chk($sformatf("vec%0d out_decerr", i), 64'(out_decerr), 64'(vecs[i].decerr));
            chk($sformatf("vec%0d out_addr", i), out_addr, vecs[i].addr);
            chk($sformatf("vec%0d out_id", i), 64'(out_id), 64'(vecs[i].id));
            chk($sformatf("vec%0d out_write", i), 64'(out_write), 64'(vecs[i].wr));
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();
        chk("stream drained out_valid", 64'(out_valid), 64'd0);
`ifdef SOC_DECODE_ERR_CAPTURE_EN
        chk("stream err_cnt", 64'(err_cnt), 64'(nmiss));
        chk("stream err_valid", 64'(err_valid), 64'd1);
        chk("stream err_addr", err_addr, first_miss);
        chk("stream small err_cnt", 64'(s_err_cnt), 64'(nmiss > 15 ? 15 : nmiss));
`else
        chk("stream err_cnt tied", 64'(err_cnt), 64'd0);
        chk("stream err_valid tied", 64'(err_valid), 64'd0);
        chk("stream err_addr tied", err_addr, 64'd0);
`endif

        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clear err_cnt", 64'(err_cnt), 64'd0);
        chk("clear err_valid", 64'(err_valid), 64'd0);
        drive(1'b1, 64'hA000_0000, 5'd1, 1'b0); tick();
        drive(1'b1, 64'hB000_0000, 5'd2, 1'b0); tick();
        drive(1'b1, 64'hC000_0000, 5'd3, 1'b0); tick();
        drive(1'b0, '0, '0, 1'b0); tick();
`ifdef SOC_DECODE_ERR_CAPTURE_EN
        chk("capture err_cnt", 64'(err_cnt), 64'd3);
        chk("capture err_valid", 64'(err_valid), 64'd1);
        chk("capture err_addr", err_addr, 64'hA000_0000);
`else
        chk("capture err_cnt tied", 64'(err_cnt), 64'd0);
        chk("capture err_addr tied", err_addr, 64'd0);
`endif

        err_clear = 1'b1;
        drive(1'b1, 64'hD000_0000, 5'd4, 1'b1);
        tick();
        err_clear = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        chk("collide out_idx", 64'(out_idx), 64'd13);
`ifdef SOC_DECODE_ERR_CAPTURE_EN
        chk("collide err_cnt", 64'(err_cnt), 64'd1);
        chk("collide err_valid", 64'(err_valid), 64'd1);
        chk("collide err_addr", err_addr, 64'hD000_0000);
        chk("collide small err_cnt", 64'(s_err_cnt), 64'd1);
`else
        chk("collide err_valid tied", 64'(err_valid), 64'd0);
`endif

        for (int k = 0; k < 13; k++) begin
            drive(1'b1, 64'hE000_0000 + 64'(k), 5'(k), 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();
`ifdef SOC_DECODE_ERR_CAPTURE_EN
        chk("near max small err_cnt", 64'(s_err_cnt), 64'd14);
`endif
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 64'hF000_0000 + 64'(k), 5'(k), 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0);
        tick();
`ifdef SOC_DECODE_ERR_CAPTURE_EN
        chk("saturate small err_cnt", 64'(s_err_cnt), 64'd15);
        chk("saturate big err_cnt", 64'(err_cnt), 64'd17);
        chk("saturate err_addr kept", err_addr, 64'hD000_0000);
`else
        chk("saturate small err_cnt tied", 64'(s_err_cnt), 64'd0);
`endif

        // Backpressure: third beat must wait until the skid entry has moved up.
        out_ready = 1'b0;
        drive(1'b1, 64'h4000_0000, 5'd1, 1'b0);
        tick();
        chk("bp1 out_valid", 64'(out_valid), 64'd1);
        chk("bp1 out_id", 64'(out_id), 64'd1);
        chk("bp1 req_ready", 64'(req_ready), 64'd1);
        drive(1'b1, 64'h1_0000, 5'd2, 1'b1);
        tick();
        chk("bp2 req_ready low", 64'(req_ready), 64'd0);
        chk("bp2 out_id held", 64'(out_id), 64'd1);
        drive(1'b1, 64'hA000_0000, 5'd3, 1'b0);
        tick();
        chk("bp3 req_ready low", 64'(req_ready), 64'd0);
        chk("bp3 out_id held", 64'(out_id), 64'd1);
        chk("bp3 out_addr held", out_addr, 64'h4000_0000);
        chk("bp3 out_idx held", 64'(out_idx), 64'd10);
        out_ready = 1'b1;
        tick();
        chk("bp4 out_id", 64'(out_id), 64'd2);
        chk("bp4 out_idx", 64'(out_idx), 64'd1);
        chk("bp4 out_write", 64'(out_write), 64'd1);
        chk("bp4 req_ready", 64'(req_ready), 64'd1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        chk("bp5 out_id", 64'(out_id), 64'd3);
        chk("bp5 out_decerr", 64'(out_decerr), 64'd1);
        chk("bp5 out_valid", 64'(out_valid), 64'd1);
        tick();
        chk("bp6 out_valid", 64'(out_valid), 64'd0);

        // Fill both entries, then reset mid-stream.
        out_ready = 1'b0;
        drive(1'b1, 64'hA000_0000, 5'd5, 1'b0); tick();
        drive(1'b1, 64'hB000_0000, 5'd6, 1'b1); tick();
        chk("pre-reset req_ready", 64'(req_ready), 64'd0);
        rst_ni = 1'b0;
        drive(1'b1, 64'hC000_0000, 5'd7, 1'b0);
        tick();
        rst_ni = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst err_cnt", 64'(err_cnt), 64'd0);
        chk("rst err_valid", 64'(err_valid), 64'd0);
        chk("rst out_id", 64'(out_id), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post-rst%0d out_valid", k), 64'(out_valid), 64'd0);
        end
        chk("post-rst err_cnt", 64'(err_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
